// File: rtl/dm_tx_framer.sv
// Frame sequencer for the differential Manchester encoder: preamble, sync word,
// streamed payload, CRC-8 and idle gap, one bit per tx_ce strobe.
module dm_tx_framer #(
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [7:0]  SYNC_WORD     = 8'hD5,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned GAP_BITS      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_ce,
  output logic                 tx_sdata,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err_underrun
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_PAY,
    S_CRC,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [7:0]           sh_q, sh_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [LEN_WIDTH-1:0] left_q, left_d;
  logic [LEN_WIDTH-1:0] fetch_q, fetch_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [7:0]           crc_q, crc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic       last_bit;
  logic       boundary;
  logic       underrun;
  logic       xfer;
  logic [7:0] next_byte;
  logic [7:0] crc_upd;

  // A byte boundary is the last bit of sync or of a payload byte with payload still owed.
  assign last_bit  = (bit_q == CNT_W'(7));
  assign boundary  = tx_ce && last_bit && (left_q != '0) &&
                     ((state_q == S_SYNC) || (state_q == S_PAY));
  assign underrun  = boundary && !hold_vld_q;
  // The slot that just underran has been written off, so its late byte is refused.
  assign s_ready   = busy_q && !hold_vld_q && (fetch_q != '0) && !underrun;
  assign xfer      = s_valid && s_ready;
  assign next_byte = hold_vld_q ? hold_q : 8'h00;
  assign crc_upd   = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ tx_q) ? 8'h07 : 8'h00);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    left_d     = left_q;
    fetch_d    = fetch_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    crc_d      = crc_q;
    err_d      = err_q;
    done_d     = 1'b0;

    if (boundary && hold_vld_q) hold_vld_d = 1'b0;
    if (underrun) begin
      fetch_d = fetch_q - LEN_WIDTH'(1);
      err_d   = 1'b1;
    end
    if (xfer) begin
      hold_d     = s_data;
      hold_vld_d = 1'b1;
      fetch_d    = fetch_q - LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PRE;
          tx_d       = 1'b1;
          bit_d      = '0;
          left_d     = len;
          fetch_d    = len;
          hold_vld_d = 1'b0;
          crc_d      = 8'h00;
          err_d      = 1'b0;
        end
      end
      S_PRE: begin
        if (tx_ce) begin
          if (bit_q == CNT_W'(PREAMBLE_BITS - 1)) begin
            state_d = S_SYNC;
            sh_d    = SYNC_WORD;
            tx_d    = SYNC_WORD[7];
            bit_d   = '0;
          end else begin
            tx_d  = bit_q[0];
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      S_SYNC, S_PAY: begin
        if (tx_ce) begin
          if (state_q == S_PAY) crc_d = crc_upd;
          if (!last_bit) begin
            sh_d  = {sh_q[6:0], 1'b0};
            tx_d  = sh_q[6];
            bit_d = bit_q + CNT_W'(1);
          end else if (left_q != '0) begin
            state_d = S_PAY;
            sh_d    = next_byte;
            tx_d    = next_byte[7];
            left_d  = left_q - LEN_WIDTH'(1);
            bit_d   = '0;
          end else begin
            // crc_d already holds the final CRC here (crc_q when len was zero)
            state_d = S_CRC;
            sh_d    = crc_d;
            tx_d    = crc_d[7];
            bit_d   = '0;
          end
        end
      end
      S_CRC: begin
        if (tx_ce) begin
          if (last_bit) begin
            state_d = S_GAP;
            tx_d    = 1'b0;
            bit_d   = '0;
          end else begin
            sh_d  = {sh_q[6:0], 1'b0};
            tx_d  = sh_q[6];
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tx_ce) begin
          if (bit_q == CNT_W'(GAP_BITS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b0;
      sh_q       <= 8'h00;
      bit_q      <= '0;
      left_q     <= '0;
      fetch_q    <= '0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      crc_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      left_q     <= left_d;
      fetch_q    <= fetch_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      crc_q      <= crc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_sdata     = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_underrun = err_q;

endmodule
